// File: rtl/serial_paralelo_sync.sv
// serial_paralelo_sync -- receive-side deserializer with K28.5/COM symbol lock.
//
// Samples data_in MSB-first on every clk_32f edge. It searches for COM_CHAR at
// any bit offset and locks after BC_LOCK_COUNT aligned COMs. Once locked, it
// presents one registered byte per 8 clocks. valid_out is low for COM (idle)
// bytes.
//
// Optional build macro: SP_MISALIGN_CNT_EN
//   When defined, adds the misalign_cnt output. This saturating counter
//   records COMs seen at a misaligned offset while locked.
module serial_paralelo_sync #(
    parameter logic [7:0]  COM_CHAR      = 8'hBC,
    parameter int unsigned BC_LOCK_COUNT = 4      // legal 1..15
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
`ifdef SP_MISALIGN_CNT_EN
    ,
    output logic [7:0] misalign_cnt
`endif
);

    localparam logic [3:0] LOCK_N = 4'(BC_LOCK_COUNT);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_ALIGN = 2'd1,
        S_LOCK  = 2'd2
    } state_e;

    state_e     state_q,    state_d;
    logic [7:0] sr_q,       sr_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [3:0] bc_cnt_q,   bc_cnt_d;
    logic [7:0] data_q,     data_d;
    logic       valid_q,    valid_d;
    logic       active_q,   active_d;
`ifdef SP_MISALIGN_CNT_EN
    logic [7:0] mis_q,      mis_d;
`endif

    // Candidate byte including the bit being sampled on this edge
    logic [7:0] nxt;
    logic       is_com;
    logic       byte_done;
    logic [3:0] bc_inc;

    // Byte window and boundary decode
    always_comb begin
        nxt       = {sr_q[6:0], data_in};
        is_com    = (nxt == COM_CHAR);
        byte_done = (bit_cnt_q == 3'd7);
        bc_inc    = bc_cnt_q + 4'd1;
    end

    // Next-state: hunt for COM, confirm alignment, then deliver bytes
    always_comb begin
        state_d   = state_q;
        sr_d      = nxt;
        bit_cnt_d = bit_cnt_q + 3'd1;  // free-running, 7 wraps to 0
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;
`ifdef SP_MISALIGN_CNT_EN
        mis_d     = mis_q;
`endif

        unique case (state_q)
            S_HUNT: begin
                valid_d = 1'b0;
                // Any offset: a COM resets the byte boundary to this edge
                if (is_com) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 4'd1;
                    if (LOCK_N == 4'd1) begin
                        state_d  = S_LOCK;
                        active_d = 1'b1;
                        data_d   = COM_CHAR;
                        valid_d  = 1'b0;
                    end else begin
                        state_d  = S_ALIGN;
                    end
                end
            end

            S_ALIGN: begin
                valid_d = 1'b0;
                // Only byte boundaries count; a non-COM there restarts the hunt.
                // The hunt check is not applied on this edge.
                if (byte_done) begin
                    if (is_com) begin
                        bc_cnt_d = bc_inc;
                        if (bc_inc >= LOCK_N) begin
                            bc_cnt_d = LOCK_N;
                            state_d  = S_LOCK;
                            active_d = 1'b1;
                            data_d   = COM_CHAR;
                            valid_d  = 1'b0;
                        end
                    end else begin
                        state_d  = S_HUNT;
                        bc_cnt_d = 4'd0;
                    end
                end
            end

            S_LOCK: begin
                // Sticky: only reset leaves this state
                if (byte_done) begin
                    data_d  = nxt;
                    valid_d = ~is_com;
                end
`ifdef SP_MISALIGN_CNT_EN
                else if (is_com && (mis_q != 8'hFF)) begin
                    mis_d = mis_q + 8'd1;
                end
`endif
            end

            default: begin
                state_d  = S_HUNT;
                bc_cnt_d = 4'd0;
                valid_d  = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    // State and output registers; everything clears asynchronously on reset
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= S_HUNT;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
`ifdef SP_MISALIGN_CNT_EN
            mis_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
`ifdef SP_MISALIGN_CNT_EN
            mis_q     <= mis_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;
`ifdef SP_MISALIGN_CNT_EN
    assign misalign_cnt = mis_q;
`endif

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Directed bench for serial_paralelo_sync.
// Bits are driven 1 time unit after a rising edge and sampled on the next edge.
// Outputs are checked 1 time unit after that edge.
module tb_serial_paralelo_sync;

    logic       clk_32f = 1'b0;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef SP_MISALIGN_CNT_EN
    logic [7:0] misalign_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    serial_paralelo_sync dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef SP_MISALIGN_CNT_EN
        ,
        .misalign_cnt (misalign_cnt)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        logic [7:0] c3;
        reset_L = 1'b1;
        data_in = 1'b0;
        #2;
        reset_L = 1'b0;

        // Reset holds all outputs clear while data toggles
        for (int i = 0; i < 4; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            chk("rst_data", {24'h0, data_out}, 32'h00);
            chk("rst_valid", {31'h0, valid_out}, 32'h0);
            chk("rst_active", {31'h0, active}, 32'h0);
        end
`ifdef SP_MISALIGN_CNT_EN
        chk("rst_mis", {24'h0, misalign_cnt}, 32'h00);
`endif
        reset_L = 1'b1;

        // Clean lock: four aligned COMs from the first bit after release
        repeat (3) send_byte(8'hBC);
        chk("clean_pre_active", {31'h0, active}, 32'h0);
        for (int i = 7; i >= 1; i--) send_bit(1'((8'hBC >> i) & 8'h01));
        chk("clean_pre_bit0", {31'h0, active}, 32'h0);
        send_bit(1'b0);
        chk("clean_active", {31'h0, active}, 32'h1);
        chk("clean_valid", {31'h0, valid_out}, 32'h0);
        chk("clean_data", {24'h0, data_out}, 32'hBC);

        // Arbitrary offset: 3 junk bits precede the COM run
        do_reset();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        repeat (3) send_byte(8'hBC);
        chk("ofs_pre_active", {31'h0, active}, 32'h0);
        send_byte(8'hBC);
        chk("ofs_active", {31'h0, active}, 32'h1);
        send_byte(8'h5A);
        chk("ofs_5a_data", {24'h0, data_out}, 32'h5A);
        chk("ofs_5a_valid", {31'h0, valid_out}, 32'h1);
        c3 = 8'hC3;
        for (int i = 7; i >= 1; i--) begin
            send_bit(c3[i]);
            chk("ofs_5a_hold", {23'h0, valid_out, data_out}, 32'h15A);
        end
        send_bit(c3[0]);
        chk("ofs_c3_data", {24'h0, data_out}, 32'hC3);
        chk("ofs_c3_valid", {31'h0, valid_out}, 32'h1);
        send_byte(8'hBC);
        chk("ofs_idle_valid", {31'h0, valid_out}, 32'h0);
        chk("ofs_idle_data", {24'h0, data_out}, 32'hBC);

        // ALIGN abort: a data byte after 2 COMs sends the hunt back to the start
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("abort_after2", {31'h0, active}, 32'h0);
        send_byte(8'h12);
        chk("abort_on12", {31'h0, active}, 32'h0);
        repeat (3) send_byte(8'hBC);
        chk("abort_after3", {31'h0, active}, 32'h0);
        send_byte(8'hBC);
        chk("abort_lock", {31'h0, active}, 32'h1);

        // Reset mid-byte while locked
        send_byte(8'hA5);
        chk("mid_pre_data", {23'h0, valid_out, data_out}, 32'h1A5);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        reset_L = 1'b0;
        #1;
        chk("mid_rst_data", {24'h0, data_out}, 32'h00);
        chk("mid_rst_valid", {31'h0, valid_out}, 32'h0);
        chk("mid_rst_active", {31'h0, active}, 32'h0);
        repeat (2) @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
        repeat (3) send_byte(8'hBC);
        chk("relock_pre", {31'h0, active}, 32'h0);
        send_byte(8'hBC);
        chk("relock", {31'h0, active}, 32'h1);

        // Misaligned COMs while locked: lock holds
        send_bit(1'b0); send_bit(1'b0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        repeat (6) send_bit(1'b0);
        chk("mis_active", {31'h0, active}, 32'h1);
        chk("mis_byte", {23'h0, valid_out, data_out}, 32'h100);
`ifdef SP_MISALIGN_CNT_EN
        chk("mis_cnt", {24'h0, misalign_cnt}, 32'h02);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
